mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port core memory (1024 x 32-bit, word-indexed, one-cycle registered read, write on clock edge).
- Shares the memory between the instruction-fetch port (read-only) and the load/store data port.
- Uses round-robin arbitration, checks alignment and range, and returns exactly one response per accepted request, one cycle after grant.
- Sits between the core pipeline and the memory block.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 38 +++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_DEPTH = 1024;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the port not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_if,
  input  logic req_d,
  output logic gnt_if,
  output logic gnt_d
);

  port_e last_grant;

  // No grant at all while reset is held, so nothing downstream sees a request.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (rst_i) begin
      if (req_if && (!req_d || last_grant == PORT_D)) begin
        gnt_if = 1'b1;
      end else if (req_d) begin
        gnt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      last_grant <= PORT_D;
    end else if (gnt_if) begin
      last_grant <= PORT_IF;
    end else if (gnt_d) begin
      last_grant <= PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-port word memory between the fetch
// port and the load/store port; one response per grant, one cycle later.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_req_valid_i,
  output logic             if_req_ready_o,
  input  logic [XLEN-1:0]  if_req_addr_i,
  output logic             if_rsp_valid_o,
  output logic [XLEN-1:0]  if_rsp_data_o,
  output logic             if_rsp_err_o,
  input  logic             d_req_valid_i,
  output logic             d_req_ready_o,
  input  logic             d_req_we_i,
  input  logic [XLEN-1:0]  d_req_addr_i,
  input  logic [XLEN-1:0]  d_req_wdata_i,
  output logic             d_rsp_valid_o,
  output logic [XLEN-1:0]  d_rsp_data_o,
  output logic             d_rsp_err_o,
  output logic             mem_rw_o,
  output logic [IDX_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]  mem_data_o,
  input  logic [XLEN-1:0]  mem_out_i
);

  logic            gnt_if;
  logic            gnt_d;
  logic            gnt_any;
  logic [XLEN-1:0] sel_addr;
  logic            misaligned;
  logic            out_of_range;
  logic            req_err;
  logic            is_store;
  logic            do_write;

  logic            vld_if_p1;
  logic            vld_d_p1;
  logic            err_p1;
  logic            rd_p1;

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_if (if_req_valid_i),
    .req_d  (d_req_valid_i),
    .gnt_if (gnt_if),
    .gnt_d  (gnt_d)
  );

  assign gnt_any        = gnt_if | gnt_d;
  assign if_req_ready_o = gnt_if;
  assign d_req_ready_o  = gnt_d;

  // Stage p0: grant cycle -- address check and memory drive
  assign sel_addr     = gnt_if ? if_req_addr_i : d_req_addr_i;
  assign misaligned   = |sel_addr[1:0];
  assign out_of_range = |sel_addr[XLEN-1:IDX_W+2];
  assign req_err      = misaligned | out_of_range;
  assign is_store     = gnt_d & d_req_we_i;
  assign do_write     = is_store & ~req_err;

  // Memory has no enable, so idle cycles issue a harmless read of word 0.
  always_comb begin
    mem_rw_o   = MEM_RD;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (gnt_any) begin
      mem_addr_o = sel_addr[IDX_W+1:2];
    end
    if (do_write) begin
      mem_rw_o   = MEM_WR;
      mem_data_o = d_req_wdata_i;
    end
  end

  // Stage p1: response cycle -- registered flags qualify the memory read data
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      vld_if_p1 <= 1'b0;
      vld_d_p1  <= 1'b0;
      err_p1    <= 1'b0;
      rd_p1     <= 1'b0;
    end else begin
      vld_if_p1 <= gnt_if;
      vld_d_p1  <= gnt_d;
      err_p1    <= gnt_any & req_err;
      rd_p1     <= gnt_any & ~req_err & ~is_store;
    end
  end

  // Reset arriving in the response cycle suppresses the pending response.
  assign if_rsp_valid_o = rst_i & vld_if_p1;
  assign if_rsp_err_o   = rst_i & vld_if_p1 & err_p1;
  assign if_rsp_data_o  = (rst_i & vld_if_p1 & rd_p1) ? mem_out_i : '0;

  assign d_rsp_valid_o  = rst_i & vld_d_p1;
  assign d_rsp_err_o    = rst_i & vld_d_p1 & err_p1;
  assign d_rsp_data_o   = (rst_i & vld_d_p1 & rd_p1) ? mem_out_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 1024x32 registered memory.
module tb_mem_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 1024;
  localparam int IDX_W = 10;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             if_req_valid_i;
  logic             if_req_ready_o;
  logic [XLEN-1:0]  if_req_addr_i;
  logic             if_rsp_valid_o;
  logic [XLEN-1:0]  if_rsp_data_o;
  logic             if_rsp_err_o;
  logic             d_req_valid_i;
  logic             d_req_ready_o;
  logic             d_req_we_i;
  logic [XLEN-1:0]  d_req_addr_i;
  logic [XLEN-1:0]  d_req_wdata_i;
  logic             d_rsp_valid_o;
  logic [XLEN-1:0]  d_rsp_data_o;
  logic             d_rsp_err_o;
  logic             mem_rw_o;
  logic [IDX_W-1:0] mem_addr_o;
  logic [XLEN-1:0]  mem_data_o;
  logic [XLEN-1:0]  mem_out_i;

  mem_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .if_req_valid_i (if_req_valid_i),
    .if_req_ready_o (if_req_ready_o),
    .if_req_addr_i  (if_req_addr_i),
    .if_rsp_valid_o (if_rsp_valid_o),
    .if_rsp_data_o  (if_rsp_data_o),
    .if_rsp_err_o   (if_rsp_err_o),
    .d_req_valid_i  (d_req_valid_i),
    .d_req_ready_o  (d_req_ready_o),
    .d_req_we_i     (d_req_we_i),
    .d_req_addr_i   (d_req_addr_i),
    .d_req_wdata_i  (d_req_wdata_i),
    .d_rsp_valid_o  (d_rsp_valid_o),
    .d_rsp_data_o   (d_rsp_data_o),
    .d_rsp_err_o    (d_rsp_err_o),
    .mem_rw_o       (mem_rw_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_out_i      (mem_out_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (i * 32'h0001_0001) ^ 32'hA5A5_0000;
  endfunction

  // Core memory: write on the edge, registered read; filled on its first edge.
  logic [31:0] tmem [DEPTH];
  bit          mem_init = 1'b0;
  always @(posedge clk_i) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) tmem[i] <= init_word(i);
      mem_init  <= 1'b1;
      mem_out_i <= '0;
    end else begin
      if (mem_rw_o) tmem[mem_addr_o] <= mem_data_o;
      mem_out_i <= tmem[mem_addr_o];
    end
  end

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        sb_q [$];
  logic [31:0] ref_mem [DEPTH];
  logic        m_last;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) $display("FAIL %s: got %h expected %h", tag, obs, want);
    else n_pass++;
  endtask

  task automatic check_cycle();
    logic g_if, g_d, any, err, wr, e_if, e_d, e_err;
    logic [31:0] a, e_data;
    logic [IDX_W-1:0] idx;
    rsp_t e;
    g_if = 1'b0;
    g_d  = 1'b0;
    if (rst_i) begin
      if (if_req_valid_i && (!d_req_valid_i || m_last == 1'b1)) g_if = 1'b1;
      else if (d_req_valid_i) g_d = 1'b1;
    end
    any = g_if | g_d;
    a   = g_if ? if_req_addr_i : d_req_addr_i;
    err = (a[1:0] != 2'b00) || (a[31:12] != '0);
    wr  = g_d && d_req_we_i && !err;
    idx = a[11:2];
    chk("if_ready", {31'b0, if_req_ready_o}, {31'b0, g_if});
    chk("d_ready", {31'b0, d_req_ready_o}, {31'b0, g_d});
    chk("mem_rw", {31'b0, mem_rw_o}, {31'b0, wr});
    chk("mem_addr", {22'b0, mem_addr_o}, any ? {22'b0, idx} : 32'h0);
    chk("mem_data", mem_data_o, wr ? d_req_wdata_i : 32'h0);
    e_if = 1'b0; e_d = 1'b0; e_data = '0; e_err = 1'b0;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (rst_i) begin
        e_if = (e.port == 1'b0); e_d = e.port; e_data = e.data; e_err = e.err;
      end
    end
    chk("if_rsp_valid", {31'b0, if_rsp_valid_o}, {31'b0, e_if});
    chk("if_rsp_data", if_rsp_data_o, e_if ? e_data : 32'h0);
    chk("if_rsp_err", {31'b0, if_rsp_err_o}, {31'b0, e_if & e_err});
    chk("d_rsp_valid", {31'b0, d_rsp_valid_o}, {31'b0, e_d});
    chk("d_rsp_data", d_rsp_data_o, e_d ? e_data : 32'h0);
    chk("d_rsp_err", {31'b0, d_rsp_err_o}, {31'b0, e_d & e_err});
    if (!rst_i) begin
      m_last = 1'b1;
      sb_q.delete();
    end else if (any) begin
      sb_q.push_back('{port: g_d,
                       data: (err || (g_d && d_req_we_i)) ? 32'h0 : ref_mem[idx],
                       err:  err});
      if (wr) ref_mem[idx] = d_req_wdata_i;
      m_last = g_d;
    end
  endtask

  task automatic drive(input logic rst, input logic ifv, input logic [31:0] ifa,
                       input logic dv, input logic dwe, input logic [31:0] da,
                       input logic [31:0] dwd);
    rst_i          = rst;
    if_req_valid_i = ifv;
    if_req_addr_i  = ifa;
    d_req_valid_i  = dv;
    d_req_we_i     = dwe;
    d_req_addr_i   = da;
    d_req_wdata_i  = dwd;
  endtask

  task automatic step();
    @(negedge clk_i);
    check_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    m_last = 1'b1;
    // Reset, with requests asserted to confirm readies are held low
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 32'h5555_5555);
    step();
    idle();
    // Fetch of preloaded word 4
    drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    idle();
    // Store then immediate load of the same word
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    step();
    idle();
    // Reset then six cycles of contention
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0);
      step();
    end
    idle();
    // Misaligned store, then readback of the word it would have hit
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h42, 32'hFFFF_FFFF);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    step();
    idle();
    // Out-of-range fetch
    drive(1'b1, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    idle();
    // Reset landing in the response cycle of a fetch
    drive(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    drive(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h44, 32'h0);
    step();
    drive(1'b1, 1'b1, 32'h24, 1'b1, 1'b0, 32'h44, 32'h0);
    step();
    idle();
    // Random traffic over a small address window
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ia, da;
      int r;
      ia = 32'($urandom_range(0, 15)) << 2;
      da = 32'($urandom_range(0, 15)) << 2;
      r  = $urandom_range(0, 9);
      if (r == 0) ia = ia | 32'($urandom_range(1, 3));
      if (r == 1) da = da | 32'($urandom_range(1, 3));
      if (r == 2) da = da | 32'h0000_1000;
      if (r == 3) ia = ia | 32'h8000_0000;
      drive(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), ia,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), da, $urandom);
      step();
    end
    idle();
    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
